// File: rtl/mem_pkg.sv
// Shared definitions for the data memory port owner and its dump sequencer.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWaitHalt,
    StRd,
    StSend,
    StDone
  } dump_state_e;

endpackage

// File: rtl/dbg_word_counter.sv
// Word index for the dump sequencer, with a flag marking the final word.
module dbg_word_counter #(
  parameter int unsigned IdxW   = 8,
  parameter int unsigned NWords = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [IdxW-1:0] idx_o,
  output logic            last_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWords - 1);

  logic [IdxW-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == LastIdx);

endmodule

// File: rtl/data_mem_dump_ctrl.sv
// Shares the single data_mem port between the MEM stage (always first) and a
// debug dump sequencer that streams every word out over valid/ready.
module data_mem_dump_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned B       = 32,
  parameter int unsigned W       = 10,
  parameter int unsigned N_WORDS = 2 ** (W - 2)
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_pl_mem_read,
  input  logic         i_pl_mem_write,
  input  logic [W-1:0] i_pl_addr,
  input  logic [B-1:0] i_pl_data,
  output logic [B-1:0] o_pl_data,
  input  logic         i_dbg_halted,
  input  logic         i_dbg_start,
  input  logic         i_dbg_ready,
  output logic         o_dbg_valid,
  output logic [B-1:0] o_dbg_data,
  output logic [W-1:0] o_dbg_addr,
  output logic         o_dbg_busy,
  output logic         o_dbg_done,
  output logic         o_mem_read,
  output logic         o_mem_write,
  output logic [W-1:0] o_mem_addr,
  output logic [B-1:0] o_mem_data,
  input  logic [B-1:0] i_mem_data
);

  localparam int unsigned OffW = $clog2(WORD_BYTES);
  localparam int unsigned IdxW = W - OffW;

  dump_state_e     state_q;
  logic            valid_q, busy_q, done_q;
  logic [B-1:0]    data_q;
  logic [W-1:0]    addr_q;
  logic [IdxW-1:0] idx;
  logic            last;
  logic            cnt_clr, cnt_inc;
  logic            pl_req;
  logic            in_walk;
  logic [W-1:0]    word_addr;

  assign pl_req    = i_pl_mem_read | i_pl_mem_write;
  assign in_walk   = (state_q == StRd) || (state_q == StSend);
  assign word_addr = {idx, {OffW{1'b0}}};

  // Losing halt mid-walk abandons the dump, so the index restarts from zero.
  always_comb begin
    cnt_clr = (state_q == StDone) || (in_walk && !i_dbg_halted);
    cnt_inc = (state_q == StSend) && i_dbg_halted && i_dbg_ready && !last;
  end

  dbg_word_counter #(
    .IdxW   (IdxW),
    .NWords (N_WORDS)
  ) u_word_counter (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .idx_o  (idx),
    .last_o (last)
  );

  always_comb begin
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_addr  = '0;
    o_mem_data  = '0;
    if (pl_req) begin
      o_mem_read  = i_pl_mem_read;
      o_mem_write = i_pl_mem_write;
      o_mem_addr  = i_pl_addr;
      o_mem_data  = i_pl_data;
    end else if (state_q == StRd) begin
      o_mem_read = 1'b1;
      o_mem_addr = word_addr;
    end
  end

  assign o_pl_data = i_mem_data;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_dbg_start) begin
            busy_q  <= 1'b1;
            state_q <= i_dbg_halted ? StRd : StWaitHalt;
          end
        end
        StWaitHalt: begin
          if (i_dbg_halted) begin
            state_q <= StRd;
          end
        end
        StRd: begin
          if (!i_dbg_halted) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (!pl_req) begin
            data_q  <= i_mem_data;
            addr_q  <= word_addr;
            valid_q <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (!i_dbg_halted) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (i_dbg_ready) begin
            valid_q <= 1'b0;
            if (last) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_dbg_valid = valid_q;
  assign o_dbg_busy  = busy_q;
  assign o_dbg_done  = done_q;
  assign o_dbg_data  = data_q;
  assign o_dbg_addr  = addr_q;

endmodule

// File: tb/tb_data_mem_dump_ctrl.sv
// Scoreboard bench: a memory model plus queues of expected dump beats and
// pipeline load data, drained by a negedge monitor.
module tb_data_mem_dump_ctrl;

  localparam int unsigned B = 32;
  localparam int unsigned W = 10;
  localparam int unsigned N = 2 ** (W - 2);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pl_read = 1'b0, pl_write = 1'b0;
  logic [W-1:0] pl_addr = '0;
  logic [B-1:0] pl_wdata = '0;
  logic [B-1:0] pl_data;
  logic         halted = 1'b0, start = 1'b0, ready = 1'b0;
  logic         dbg_valid, dbg_busy, dbg_done;
  logic [B-1:0] dbg_data;
  logic [W-1:0] dbg_addr;
  logic         mem_read, mem_write;
  logic [W-1:0] mem_addr;
  logic [B-1:0] mem_wdata, mem_rdata;

  logic [B-1:0] mem     [N];
  logic [B-1:0] ref_mem [N];

  typedef struct packed {
    logic [W-1:0] addr;
    logic [B-1:0] data;
  } beat_t;

  beat_t        exp_q[$];
  logic [B-1:0] pl_q[$];
  int           tests = 0, fails = 0, done_exp = 0;

  always #5 clk = ~clk;

  data_mem_dump_ctrl #(.B(B), .W(W), .N_WORDS(N)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_pl_mem_read  (pl_read),
    .i_pl_mem_write (pl_write),
    .i_pl_addr      (pl_addr),
    .i_pl_data      (pl_wdata),
    .o_pl_data      (pl_data),
    .i_dbg_halted   (halted),
    .i_dbg_start    (start),
    .i_dbg_ready    (ready),
    .o_dbg_valid    (dbg_valid),
    .o_dbg_data     (dbg_data),
    .o_dbg_addr     (dbg_addr),
    .o_dbg_busy     (dbg_busy),
    .o_dbg_done     (dbg_done),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_mem_addr     (mem_addr),
    .o_mem_data     (mem_wdata),
    .i_mem_data     (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[W-1:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[W-1:2]] = mem_wdata;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // Monitor: compare every presented beat against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dbg_valid) begin
        if (exp_q.size() == 0) begin
          check("dump_extra_word", 32'(dbg_addr), 32'hffff_ffff);
        end else begin
          check("dump_addr", 32'(dbg_addr), 32'(exp_q[0].addr));
          check("dump_data", dbg_data, exp_q[0].data);
          if (ready) void'(exp_q.pop_front());
        end
      end
      if (pl_read) begin
        if (pl_q.size() == 0) check("pl_extra_load", 32'(pl_addr), 32'hffff_ffff);
        else check("pl_load_data", pl_data, pl_q.pop_front());
      end
      if (dbg_done) begin
        check("done_expected", 32'(done_exp > 0), 32'd1);
        check("done_words_left", 32'(exp_q.size()), 32'd0);
        if (done_exp > 0) done_exp--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pl_store(input int unsigned idx, input logic [B-1:0] d);
    pl_write = 1'b1;
    pl_addr  = W'(idx * 4);
    pl_wdata = d;
    ref_mem[idx] = d;
    tick();
    pl_write = 1'b0;
  endtask

  task automatic pl_load(input int unsigned idx);
    pl_read = 1'b1;
    pl_addr = W'(idx * 4);
    pl_q.push_back(ref_mem[idx]);
    tick();
    pl_read = 1'b0;
  endtask

  task automatic start_dump();
    for (int i = 0; i < int'(N); i++) exp_q.push_back('{addr: W'(i * 4), data: ref_mem[i]});
    done_exp++;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!dbg_done && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, 32'(dbg_done), 32'd1);
    tick();
    check({name, "_idle_after"}, 32'(dbg_busy), 32'd0);
  endtask

  task automatic wait_beat(input string name, input int unsigned word);
    int n = 0;
    while (!(dbg_valid && dbg_addr == W'(word * 4)) && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_beat_reached"}, 32'(dbg_valid), 32'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_valid"}, 32'(dbg_valid), 32'd0);
    check({name, "_busy"}, 32'(dbg_busy), 32'd0);
    check({name, "_done"}, 32'(dbg_done), 32'd0);
    check({name, "_data"}, dbg_data, 32'd0);
    check({name, "_addr"}, 32'(dbg_addr), 32'd0);
    check({name, "_mem_en"}, 32'({mem_read, mem_write}), 32'd0);
  endtask

  initial begin
    int n;
    #3;
    check_outputs_zero("reset");
    #9 rst_n = 1'b1;
    tick();

    // Pass-through with the pipeline running; also preloads mem[i] = i.
    for (int i = 0; i < int'(N); i++) pl_store(i, B'(i));
    for (int i = 0; i < 10; i++) begin
      pl_load(i);
      check("pass_busy", 32'(dbg_busy), 32'd0);
    end

    // Full dump with latency measured from the start cycle.
    halted = 1'b1;
    ready  = 1'b1;
    start_dump();
    n = 1;
    while (!dbg_done && n < 3000) begin
      tick();
      n++;
    end
    check("full_done_latency", n, 2 * N + 1);
    tick();
    check("full_idle_after", 32'(dbg_busy), 32'd0);

    // Backpressure on word 3.
    start_dump();
    wait_beat("bp", 3);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_held", 32'(dbg_valid), 32'd1);
    end
    ready = 1'b1;
    wait_done("bp");

    // Pipeline load collides with the read of word 7.
    start_dump();
    n = 0;
    while (!(dbg_busy && !dbg_valid && mem_read && mem_addr == W'(28)) && n < 3000) begin
      tick();
      n++;
    end
    pl_read = 1'b1;
    pl_addr = W'(40);
    pl_q.push_back(ref_mem[10]);
    #1;
    check("coll_mem_addr", 32'(mem_addr), 32'd40);
    tick();
    pl_read = 1'b0;
    wait_done("coll");

    // Halt drops while word 5 is waiting; dump abandoned without done.
    start_dump();
    wait_beat("abort", 5);
    ready  = 1'b0;
    halted = 1'b0;
    tick();
    check("abort_valid", 32'(dbg_valid), 32'd0);
    check("abort_busy", 32'(dbg_busy), 32'd0);
    exp_q.delete();
    done_exp = 0;
    repeat (3) tick();
    halted = 1'b1;
    ready  = 1'b1;
    start_dump();
    wait_done("restart");

    // Asynchronous reset while word 9 is presented.
    start_dump();
    wait_beat("rst", 9);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    done_exp = 0;
    #10 rst_n = 1'b1;
    tick();
    start_dump();
    wait_done("post_reset");

    // Random contents, start before halt, random ready, loads, ignored restart.
    halted = 1'b0;
    for (int i = 0; i < int'(N); i++) pl_store(i, $urandom);
    start_dump();
    repeat (3) begin
      check("wait_halt_busy", 32'(dbg_busy), 32'd1);
      check("wait_halt_valid", 32'(dbg_valid), 32'd0);
      tick();
    end
    halted = 1'b1;
    n = 0;
    while (!dbg_done && n < 5000) begin
      ready   = 1'($urandom_range(0, 1));
      start   = (n == 40);
      pl_read = ($urandom_range(0, 3) == 0);
      if (pl_read) begin
        int unsigned w = $urandom_range(0, N - 1);
        pl_addr = W'(w * 4);
        pl_q.push_back(ref_mem[w]);
      end
      tick();
      n++;
    end
    pl_read = 1'b0;
    start   = 1'b0;
    check("rand_done_seen", 32'(dbg_done), 32'd1);
    tick();
    check("rand_idle_after", 32'(dbg_busy), 32'd0);
    check("rand_pl_drained", 32'(pl_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
